mem_access: RTL and testbench

Memory-stage access controller for the 16-bit pipeline. Takes the ALU result as address and the store operand (register B read data) as write data. Runs one load or store at a time on an asynchronous external SRAM with a fixed number of wait states, and stalls the pipeline until the access completes. Load data returns to the write-back path with a one-cycle valid strobe.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_rdbuf.sv | 38 +++
 rtl/mem_access.sv | 127 ++++++++++++
 tb/tb_mem_access.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM access controller.
package mem_pkg;
    localparam int   DATA_WID_DEF = 16;
    localparam int   ADDR_WID_DEF = 18;
    localparam logic STROBE_OFF   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;
endpackage

// File: rtl/mem_rdbuf.sv
// Single-entry load buffer: last loaded word, kept coherent with stores to it.
module mem_rdbuf
    import mem_pkg::*;
#(
    parameter int DATA_WID = DATA_WID_DEF,
    parameter int ADDR_WID = ADDR_WID_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_WID-1:0] lk_addr,
    output logic                hit,
    output logic [DATA_WID-1:0] hit_data,
    input  logic                fill_en,
    input  logic                upd_en,
    input  logic [ADDR_WID-1:0] wr_addr,
    input  logic [DATA_WID-1:0] wr_data
);
    logic                buf_valid;
    logic [ADDR_WID-1:0] buf_addr;
    logic [DATA_WID-1:0] buf_data;

    assign hit      = buf_valid && (buf_addr == lk_addr);
    assign hit_data = buf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (fill_en) begin
            buf_valid <= 1'b1;
            buf_addr  <= wr_addr;
            buf_data  <= wr_data;
        end else if (upd_en && buf_valid && (buf_addr == wr_addr)) begin
            buf_data  <= wr_data;
        end
    end
endmodule

// File: rtl/mem_access.sv
// MEM-stage controller: one load/store at a time on an async SRAM with fixed wait states.
// Optional single-entry load buffer enabled by defining MEM_RDBUF_EN.
module mem_access
    import mem_pkg::*;
#(
    parameter int DATA_WID = DATA_WID_DEF,
    parameter int ADDR_WID = ADDR_WID_DEF,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [ADDR_WID-1:0] req_addr,
    input  logic [DATA_WID-1:0] req_wdata,
    output logic                stall,
    output logic [DATA_WID-1:0] rdata,
    output logic                rdata_valid,
    output logic [ADDR_WID-1:0] sram_addr,
    output logic [DATA_WID-1:0] sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [DATA_WID-1:0] sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);
    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                lat_we;
    logic                hit_r;
    logic                buf_hit;
    logic [DATA_WID-1:0] buf_data;
    logic                accept, hit_accept, acc_last;

    assign accept     = (state == IDLE) && req_valid;
    assign hit_accept = accept && !req_we && buf_hit;
    assign acc_last   = (state == ACCESS) && (cnt == 4'd0);
    assign stall      = req_valid && (state != DONE);

`ifdef MEM_RDBUF_EN
    mem_rdbuf #(.DATA_WID(DATA_WID), .ADDR_WID(ADDR_WID)) u_rdbuf (
        .clk      (clk),
        .rst      (rst),
        .lk_addr  (req_addr),
        .hit      (buf_hit),
        .hit_data (buf_data),
        .fill_en  (acc_last && !lat_we),
        .upd_en   (acc_last && lat_we),
        .wr_addr  (sram_addr),
        .wr_data  (lat_we ? sram_dq_o : sram_dq_i)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_nxt  = state;
        sram_ce_n  = STROBE_OFF;
        sram_oe_n  = STROBE_OFF;
        sram_we_n  = STROBE_OFF;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = (!req_we && buf_hit) ? DONE : SETUP;
            end
            SETUP: begin
                sram_ce_n = ~STROBE_OFF;
                if (lat_we) sram_dq_oe = 1'b1;
                else        sram_oe_n  = ~STROBE_OFF;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                sram_ce_n = ~STROBE_OFF;
                if (lat_we) begin
                    sram_dq_oe = 1'b1;
                    sram_we_n  = ~STROBE_OFF;
                end else begin
                    sram_oe_n  = ~STROBE_OFF;
                end
                if (cnt == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                // Hold chip select and data past the strobe; a buffer hit never touches the bus.
                sram_ce_n  = hit_r ? STROBE_OFF : ~STROBE_OFF;
                sram_dq_oe = lat_we;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            hit_r       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_o   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdata_valid <= 1'b0;
            if (accept) begin
                sram_addr <= req_addr;
                sram_dq_o <= req_wdata;
                lat_we    <= req_we;
                hit_r     <= hit_accept;
            end
            if (hit_accept) begin
                rdata       <= buf_data;
                rdata_valid <= 1'b1;
            end
            if (state == SETUP)
                cnt <= 4'(WAIT_CYC - 1);
            else if ((state == ACCESS) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (acc_last && !lat_we) begin
                rdata       <= sram_dq_i;
                rdata_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed plan steps plus randomized back-to-back traffic vs a memory model.
module tb_mem_access;
    localparam int W = 2;
`ifdef MEM_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic        clk, rst;
    logic        req_valid, req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic        stall, rdata_valid, sram_dq_oe;
    logic [15:0] rdata, sram_dq_o, sram_dq_i;
    logic [17:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic        mem_init;

    int ntests = 0;
    int nfail  = 0;

    logic [15:0] sram_mem [0:63];
    logic [15:0] ref_mem  [0:63];
    logic        buf_v;
    logic [17:0] buf_a;
    logic [15:0] last_rdata;

    mem_access #(.DATA_WID(16), .ADDR_WID(18), .WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return (i == 32) ? 16'h1234 : (16'(i * 257) ^ 16'h5A5A);
    endfunction

    // Async SRAM model: reads visible while ce_n/oe_n low, writes taken while we_n low.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= init_val(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_o;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("idle_stall", int'(stall), 0);
            check("idle_strobes", int'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 4'b1110);
            check("idle_rdata", int'(rdata), int'(last_rdata));
            check("idle_rv", int'(rdata_valid), 0);
        end
    endtask

    task automatic do_op(input logic we, input logic [17:0] addr, input logic [15:0] wd);
        int cyc, n_stall, n_we, n_oe, n_ce, n_dqoe, n_dq, n_ovl, n_badaddr, n_rv, rv_cyc;
        logic done, hit;
        logic [15:0] exp_d, got;
        hit   = RDBUF && !we && buf_v && (buf_a == addr);
        exp_d = ref_mem[addr[5:0]];
        {cyc, n_stall, n_we, n_oe, n_ce, n_dqoe, n_dq, n_ovl, n_badaddr, n_rv, rv_cyc} = '0;
        done = 1'b0;
        got  = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!done && cyc < 40) begin
            #1;
            cyc++;
            n_stall += int'(stall);
            n_we    += int'(!sram_we_n);
            n_oe    += int'(!sram_oe_n);
            n_ce    += int'(!sram_ce_n);
            n_dqoe  += int'(sram_dq_oe);
            n_dq    += int'(sram_dq_oe && (sram_dq_o == wd));
            n_ovl   += int'(!sram_we_n && !sram_oe_n);
            n_badaddr += int'(!sram_ce_n && (sram_addr != addr));
            if (rdata_valid) begin
                n_rv++;
                rv_cyc = cyc;
                got    = rdata;
            end
            if (!stall) done = 1'b1;
            else begin
                @(negedge clk);
                req_addr  = 18'($urandom);
                req_wdata = 16'($urandom);
            end
        end
        check("op_done", int'(done), 1);
        check("op_cycles", cyc, hit ? 2 : W + 3);
        check("op_stall", n_stall, hit ? 1 : W + 2);
        check("op_we_low", n_we, we ? W : 0);
        check("op_oe_low", n_oe, (!we && !hit) ? W + 1 : 0);
        check("op_ce_low", n_ce, hit ? 0 : W + 2);
        check("op_dq_oe", n_dqoe, we ? W + 2 : 0);
        check("op_dq_data", n_dq, we ? W + 2 : 0);
        check("op_overlap", n_ovl, 0);
        check("op_addr", n_badaddr, 0);
        check("op_rv_cnt", n_rv, we ? 0 : 1);
        if (!we) begin
            check("op_rv_cycle", rv_cyc, cyc);
            check("op_rdata", int'(got), int'(exp_d));
            last_rdata = exp_d;
            if (RDBUF) begin
                buf_v = 1'b1;
                buf_a = addr;
            end
        end else begin
            ref_mem[addr[5:0]] = wd;
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        buf_v = 1'b0; buf_a = '0; last_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", int'(rdata), 0);
        check("rst_rv", int'(rdata_valid), 0);
        check("rst_addr", int'(sram_addr), 0);
        check("rst_dq_o", int'(sram_dq_o), 0);
        check("rst_strobes", int'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 4'b1110);
        check("rst_stall_lo", int'(stall), 0);
        req_valid = 1'b1;
        #1;
        check("rst_stall_hi", int'(stall), 1);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0; mem_init = 1'b0;

        idle(10);

        do_op(1'b1, 18'h00010, 16'hBEEF);
        idle(2);
        do_op(1'b0, 18'h00010, 16'h0000);
        idle(1);

        // Reset lands during the first ACCESS cycle of a load.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00010;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid_oe", int'(sram_oe_n), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("rst_mid_strobes", int'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 4'b1110);
        check("rst_mid_rv", int'(rdata_valid), 0);
        check("rst_mid_rdata", int'(rdata), 0);
        check("rst_mid_stall", int'(stall), 0);
        last_rdata = '0;
        buf_v = 1'b0;
        idle(3);

        do_op(1'b0, 18'h00020, 16'h0000);
        do_op(1'b1, 18'h00020, 16'h5678);
        do_op(1'b0, 18'h00020, 16'h0000);
        idle(2);

        for (int k = 0; k < 40; k++) begin
            do_op(1'($urandom_range(0, 1)), 18'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(2);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
